// File: rtl/uc_multiciclo.sv
// uc_multiciclo: multi-cycle RV32I control unit.
// Sequences FETCH/DECODE/EXEC/MEM/WB and traps on illegal ops or memory timeout.
// In : clk, rst_n, opcode, funct3, funct7, zero, mem_ready, trap_clr
// Out: ImmSel, branch, jump, jumplink, memtoreg, ALUsrc, LUItoReg (latched decode)
//      MemR, MemW, IRW, PCW, RegW, br_taken (strobes), illegal, timeout, state
module uc_multiciclo #(
  parameter int OPW     = 7,
  parameter int TIMEOUT = 16,
  parameter int CNTW    = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPW-1:0] opcode,
  input  logic [2:0]     funct3,
  input  logic [6:0]     funct7,
  input  logic           zero,
  input  logic           mem_ready,
  input  logic           trap_clr,
  output logic [2:0]     ImmSel,
  output logic           branch,
  output logic           jump,
  output logic           jumplink,
  output logic           memtoreg,
  output logic           ALUsrc,
  output logic           LUItoReg,
  output logic           MemR,
  output logic           MemW,
  output logic           IRW,
  output logic           PCW,
  output logic           RegW,
  output logic           br_taken,
  output logic           illegal,
  output logic           timeout,
  output logic [2:0]     state
);

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    FETCH  = 3'b001,
    DECODE = 3'b010,
    EXEC   = 3'b011,
    MEM    = 3'b100,
    WB     = 3'b101,
    TRAP   = 3'b110
  } st_t;

  typedef struct packed {
    logic [2:0] imm;
    logic       br;
    logic       jmp;
    logic       jl;
    logic       mtr;
    logic       src;
    logic       lui;
    logic       ld;
    logic       st;
    logic       bne;
  } ctl_t;

  localparam logic [OPW-1:0] OP_I    = OPW'(7'b0010011);
  localparam logic [OPW-1:0] OP_LD   = OPW'(7'b0000011);
  localparam logic [OPW-1:0] OP_ST   = OPW'(7'b0100011);
  localparam logic [OPW-1:0] OP_R    = OPW'(7'b0110011);
  localparam logic [OPW-1:0] OP_LUI  = OPW'(7'b0110111);
  localparam logic [OPW-1:0] OP_BR   = OPW'(7'b1100011);
  localparam logic [OPW-1:0] OP_JAL  = OPW'(7'b1101111);
  localparam logic [OPW-1:0] OP_JALR = OPW'(7'b1100111);

  localparam bit TEN = (TIMEOUT > 0);
  localparam logic [CNTW-1:0] TLIM =
    TEN ? CNTW'(TIMEOUT - 1) : '0;

  st_t             cs;
  st_t             ns;
  ctl_t            c;
  ctl_t            d;
  logic            d_ok;
  logic [CNTW-1:0] cnt;
  logic            waiting;
  logic            tmo;
  logic            br_x;
  logic            st_x;

  always_comb begin
    d    = '0;
    d_ok = 1'b0;
    unique case (1'b1)
      opcode == OP_I: begin
        d_ok  = 1'b1;
        d.src = 1'b1;
      end
      opcode == OP_LD: begin
        d_ok  = (funct3 == 3'b010);
        d.src = 1'b1;
        d.mtr = 1'b1;
        d.ld  = 1'b1;
      end
      opcode == OP_ST: begin
        d_ok  = (funct3 == 3'b010);
        d.src = 1'b1;
        d.imm = 3'b001;
        d.st  = 1'b1;
      end
      opcode == OP_R: begin
        d_ok = (funct7 == 7'b0000000) ||
               (funct7 == 7'b0100000);
      end
      opcode == OP_LUI: begin
        d_ok  = 1'b1;
        d.src = 1'b1;
        d.lui = 1'b1;
        d.imm = 3'b011;
      end
      opcode == OP_BR: begin
        d_ok  = (funct3[2:1] == 2'b00);
        d.br  = 1'b1;
        d.imm = 3'b010;
        d.bne = funct3[0];
      end
      opcode == OP_JAL: begin
        d_ok  = 1'b1;
        d.jmp = 1'b1;
        d.jl  = 1'b1;
        d.imm = 3'b100;
      end
      opcode == OP_JALR: begin
        d_ok  = (funct3 == 3'b000);
        d.jmp = 1'b1;
        d.jl  = 1'b1;
        d.src = 1'b1;
      end
      default: ;
    endcase
  end

  // tmo fires on the last allowed wait cycle; mem_ready in that
  // same cycle masks it so completion wins.
  assign waiting = ((cs == FETCH) || (cs == MEM)) && !mem_ready;
  assign tmo     = TEN && waiting && (cnt == TLIM);
  assign br_x    = (cs == EXEC) && c.br;
  assign st_x    = (cs == MEM) && c.st && mem_ready;

  always_comb begin
    ns = cs;
    unique case (cs)
      IDLE:   ns = FETCH;
      FETCH: begin
        if (mem_ready) ns = DECODE;
        else if (tmo)  ns = TRAP;
      end
      DECODE: ns = d_ok ? EXEC : TRAP;
      EXEC: begin
        if (c.br)             ns = FETCH;
        else if (c.ld | c.st) ns = MEM;
        else                  ns = WB;
      end
      MEM: begin
        if (mem_ready) ns = c.ld ? WB : FETCH;
        else if (tmo)  ns = TRAP;
      end
      WB:     ns = FETCH;
      TRAP:   if (trap_clr) ns = FETCH;
      default: ns = IDLE;
    endcase
  end

  // Level strobes follow the state being entered; exit pulses
  // (IRW, branch/store PCW) show in the first cycle after the exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs       <= IDLE;
      cnt      <= '0;
      c        <= '0;
      illegal  <= 1'b0;
      timeout  <= 1'b0;
      MemR     <= 1'b0;
      MemW     <= 1'b0;
      IRW      <= 1'b0;
      PCW      <= 1'b0;
      RegW     <= 1'b0;
      br_taken <= 1'b0;
    end else begin
      cs <= ns;
      if (ns != cs)
        cnt <= '0;
      else if (waiting && (cnt != '1))
        cnt <= cnt + 1'b1;
      if ((cs == DECODE) && d_ok)
        c <= d;
      else if ((cs == TRAP) && trap_clr)
        c <= '0;
      if ((cs == DECODE) && !d_ok)
        illegal <= 1'b1;
      else if ((cs == TRAP) && trap_clr)
        illegal <= 1'b0;
      if (tmo)
        timeout <= 1'b1;
      else if ((cs == TRAP) && trap_clr)
        timeout <= 1'b0;
      MemR     <= (ns == FETCH) ||
                  ((ns == MEM) && c.ld);
      MemW     <= (ns == MEM) && c.st;
      IRW      <= (cs == FETCH) && mem_ready;
      RegW     <= (ns == WB);
      PCW      <= (ns == WB) || br_x || st_x;
      br_taken <= ((ns == WB) && c.jmp) ||
                  (br_x && (zero ^ c.bne));
    end
  end

  assign ImmSel   = c.imm;
  assign branch   = c.br;
  assign jump     = c.jmp;
  assign jumplink = c.jl;
  assign memtoreg = c.mtr;
  assign ALUsrc   = c.src;
  assign LUItoReg = c.lui;
  assign state    = cs;

endmodule
